iob_merge_rr: RTL and testbench
===============================

Name: iob_merge_rr

Overview:
- N-master to 1-slave merger on the IOB native bus. It sits directly upstream of the address-based splitter: the CPU instruction and data ports are merged into one request stream here, and that stream feeds the splitter.
- Arbitration is round-robin. The grant is locked for the whole transaction, from valid until ready.
- The response is routed back only to the master that owns the grant.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 32, address width in bits.
- N_MASTERS, 2, number of masters. Legal range is 2..16.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. Synchronous, active-high.
- m_req  input  N_MASTERS*REQ_W  master requests. Slot i is bits [i*REQ_W +: REQ_W]. Fields, MSB to LSB: {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}.
- m_resp  output  N_MASTERS*RESP_W  master responses. Slot i is bits [i*RESP_W +: RESP_W]. Fields: {rdata[DATA_W], ready}.
- s_req  output  REQ_W  merged request to the downstream splitter or slave.
- s_resp  input  RESP_W  response from downstream.
- grant  output  Nb  index of the current or last granted master. Nb = max(1, clog2(N_MASTERS)).
- busy  output  1  high while a transaction is outstanding.

Behaviour:
- Widths: REQ_W = 1+ADDR_W+DATA_W+DATA_W/8 and RESP_W = DATA_W+1, taken from the shared interconnect header.
- Reset state (clk edge with rst=1): state=IDLE, grant=0, rr_ptr=0, busy=0.
  - s_req is all zeros.
  - m_resp is all zeros.
  - Reset mid-transaction aborts that transaction. The slave's ready in the following cycle is ignored: in IDLE, s_resp is not routed.
- FSM states: IDLE and BUSY.
- IDLE:
  - s_req = 0 and m_resp = 0.
  - If any m_req valid bit is set, the winner is the first valid index searching from rr_ptr upward, with wrap-around.
  - On that edge: grant <= winner, state <= BUSY.
  - If no valid bit is set, stay in IDLE.
- BUSY:
  - busy=1.
  - s_req = m_req slot[grant], passed through combinationally. Address, wdata and wstrb of the granted master are tracked cycle by cycle.
  - m_resp slot[grant] = s_resp. All other slots are 0.
  - When s_resp.ready=1: rr_ptr <= (grant+1) mod N_MASTERS, then state <= IDLE.
  - ready is assumed to be a 1-cycle pulse.
- Latency:
  - One cycle of arbitration. A request presented at edge k reaches s_req valid in cycle k+1.
  - After ready there is at least one IDLE cycle with s_req.valid=0. Back-to-back transactions are therefore separated by 1 idle cycle, so a held valid is never seen twice by the slave.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0,... Starvation bound is N-1 transactions.
- Granted master drops valid before ready:
  - This is a protocol violation.
  - The block stays in BUSY, forwards valid=0, and still waits for ready.
  - It does not release the grant without ready. No timeout.
- Ready while IDLE: ignored and not routed to any master.
- N_MASTERS not a power of two: rr_ptr wraps at N_MASTERS-1 → 0. Indices ≥ N_MASTERS never win.
- grant holds its last value in IDLE until the next arbitration.

Decomposition:
- Shared interconnect header/package holds:
  - REQ_W and RESP_W.
  - The valid/addr/wdata/wstrb/rdata/ready field offsets.
  - The req(i)/resp(i) slot slicing macros. These are the same ones the splitter uses.
  - The state encodings, IDLE=0 and BUSY=1.
- Sub-module iob_rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr[Nb].
  - Outputs: gnt_idx[Nb], any.
  - Purely combinational masked priority picker, reusable by later crossbars.
- The FSM, pointer and muxing live in iob_merge_rr.

Test Plan:
- Reset, then single request. Master 1 presents valid, addr=0x100, wdata=0xDEADBEEF, wstrb=0xF. Slave asserts ready 2 cycles after s_req.valid. Required: s_req.valid rises 1 cycle after m_req, grant=1, m_resp1.ready pulses once, m_resp0 stays 0, and s_req=0 the cycle after ready.
- Contention. Masters 0 and 1 both assert valid continuously from reset. Required: grant sequence 0,1,0,1 over 4 transactions, each separated by exactly 1 idle cycle.
- Read data routing. Master 0 reads addr=0x4 and the slave returns rdata=0x12345678 with ready. Required: m_resp0.rdata=0x12345678 with ready=1, and m_resp1=0 in that same cycle.
- Spurious ready. Slave pulses ready while the block is IDLE with no requests. Required: all m_resp stay 0 and the state stays IDLE.
- Reset mid-transaction. rst is asserted in BUSY with grant=1, and the slave asserts ready the cycle after. Required: busy=0 and s_req=0 immediately after the reset edge, that ready is not routed, and the next arbitration starts from rr_ptr=0.
- N_MASTERS=3 wrap. Masters 0 and 2 request continuously. Required: grant sequence 0,2,0,2; index 1 is skipped and rr_ptr wraps 2→0.

Source files
------------

// File: rtl/iob_merge_rr_pkg.sv
// Shared IOB interconnect definitions: bus widths, field offsets,
// slot helpers and merger state encodings used by merger and splitter.
package iob_merge_rr_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } merge_state_t;

    // Request bundle, MSB to LSB: {valid, addr, wdata, wstrb}
    function automatic int req_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    // Response bundle, MSB to LSB: {rdata, ready}
    function automatic int resp_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int valid_bit(input int aw, input int dw);
        return aw + dw + dw / 8;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw + dw / 8;
    endfunction

    function automatic int wdata_lsb(input int dw);
        return dw / 8;
    endfunction

    localparam int WSTRB_LSB = 0;
    localparam int READY_BIT = 0;
    localparam int RDATA_LSB = 1;

    // Slot i of a packed request/response array starts here
    function automatic int req_slot(input int i, input int aw, input int dw);
        return i * req_w(aw, dw);
    endfunction

    function automatic int resp_slot(input int i, input int dw);
        return i * resp_w(dw);
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin picker: first set req bit from ptr upward.
// Ports: req[N] requests, ptr start index -> gnt_idx winner, any hit.
module iob_rr_arbiter
    import iob_merge_rr_pkg::*;
#(
    parameter  int N  = 2,
    localparam int NB = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [NB-1:0] ptr,
    output logic [NB-1:0] gnt_idx,
    output logic          any
);

    int idx;

    // Walk the offsets from farthest to nearest so the nearest
    // requester to ptr is the last (winning) assignment.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = NB'(idx);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_merge_rr.sv
// N-to-1 IOB merger with round-robin arbitration and locked grant.
// Ports: m_req/m_resp master slots, s_req/s_resp slave, grant, busy.
module iob_merge_rr
    import iob_merge_rr_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int N_MASTERS = 2,
    localparam int REQ_W     = req_w(ADDR_W, DATA_W),
    localparam int RESP_W    = resp_w(DATA_W),
    localparam int NB        = idx_w(N_MASTERS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [NB-1:0]               grant,
    output logic                        busy
);

    localparam int VBIT = valid_bit(ADDR_W, DATA_W);

    merge_state_t    state, state_nxt;
    logic [NB-1:0]   rr_ptr, ptr_nxt, grant_nxt;
    logic [NB-1:0]   arb_idx;
    logic            arb_any;
    logic [N_MASTERS-1:0] m_valid;
    logic            s_ready;

    always_comb begin
        m_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = m_req[req_slot(i, ADDR_W, DATA_W) + VBIT];
        end
    end

    assign s_ready = s_resp[READY_BIT];

    iob_rr_arbiter #(
        .N (N_MASTERS)
    ) u_arb (
        .req     (m_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= ptr_nxt;
        end
    end

    // A dropped valid in BUSY does not release the grant: only ready does.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = rr_ptr;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = BUSY;
                    grant_nxt = arb_idx;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (grant == NB'(N_MASTERS - 1))
                              ? '0 : grant + NB'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave side sees only the owner; responses return only to it.
    always_comb begin
        busy   = (state == BUSY);
        s_req  = '0;
        m_resp = '0;
        if (state == BUSY) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (grant == NB'(i)) begin
                    s_req = m_req[req_slot(i, ADDR_W, DATA_W) +: REQ_W];
                    m_resp[resp_slot(i, DATA_W) +: RESP_W] = s_resp;
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_merge_rr.sv
// Directed bench for iob_merge_rr: 2-master and 3-master instances.
// Each task drives its scenario and checks against hand-computed values.
module tb_iob_merge_rr;

    localparam int RQ = 69;
    localparam int RS = 33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [2*RQ-1:0] m_req2;
    logic [2*RS-1:0] m_resp2;
    logic [RQ-1:0]   s_req2;
    logic [RS-1:0]   s_resp2;
    logic            grant2;
    logic            busy2;

    logic [3*RQ-1:0] m_req3;
    logic [3*RS-1:0] m_resp3;
    logic [RQ-1:0]   s_req3;
    logic [RS-1:0]   s_resp3;
    logic [1:0]      grant3;
    logic            busy3;

    int total = 0;
    int bad   = 0;

    iob_merge_rr #(.DATA_W(32), .ADDR_W(32), .N_MASTERS(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req2),
        .m_resp (m_resp2),
        .s_req  (s_req2),
        .s_resp (s_resp2),
        .grant  (grant2),
        .busy   (busy2)
    );

    iob_merge_rr #(.DATA_W(32), .ADDR_W(32), .N_MASTERS(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req3),
        .m_resp (m_resp3),
        .s_req  (s_req3),
        .s_resp (s_resp3),
        .grant  (grant3),
        .busy   (busy3)
    );

    function automatic logic [RQ-1:0] mk_req(input logic v,
        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy2 got=%0b want=0", busy2); end
        total++; if (grant2 !== 1'b0) begin bad++; $display("FAIL reset_grant2 got=%0d want=0", grant2); end
        total++; if (s_req2 !== '0) begin bad++; $display("FAIL reset_sreq2 got=%h want=0", s_req2); end
        total++; if (m_resp2 !== '0) begin bad++; $display("FAIL reset_mresp2 got=%h want=0", m_resp2); end
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL reset_busy3 got=%0b want=0", busy3); end
        total++; if (grant3 !== 2'd0) begin bad++; $display("FAIL reset_grant3 got=%0d want=0", grant3); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [RQ-1:0] r1;
        r1 = mk_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        m_req2 = {r1, {RQ{1'b0}}};
        #1;
        total++; if (s_req2 !== '0) begin bad++; $display("FAIL single_pre got=%h want=0", s_req2); end
        tick();
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b want=1", busy2); end
        total++; if (grant2 !== 1'b1) begin bad++; $display("FAIL single_grant got=%0d want=1", grant2); end
        total++; if (s_req2 !== r1) begin bad++; $display("FAIL single_sreq got=%h want=%h", s_req2, r1); end
        total++; if (m_resp2 !== '0) begin bad++; $display("FAIL single_resp_c1 got=%h want=0", m_resp2); end
        tick();
        total++; if (m_resp2 !== '0) begin bad++; $display("FAIL single_resp_c2 got=%h want=0", m_resp2); end
        s_resp2 = {32'h0, 1'b1};
        #1;
        total++; if (m_resp2[RS +: RS] !== {32'h0, 1'b1}) begin bad++; $display("FAIL single_resp1 got=%h want=1", m_resp2[RS +: RS]); end
        total++; if (m_resp2[0 +: RS] !== '0) begin bad++; $display("FAIL single_resp0 got=%h want=0", m_resp2[0 +: RS]); end
        tick();
        m_req2  = '0;
        s_resp2 = '0;
        #1;
        total++; if (s_req2 !== '0) begin bad++; $display("FAIL single_after got=%h want=0", s_req2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b want=0", busy2); end
        total++; if (m_resp2 !== '0) begin bad++; $display("FAIL single_resp_c4 got=%h want=0", m_resp2); end
    endtask

    task automatic test_contention();
        logic [RQ-1:0] a0, a1;
        logic          e;
        a0 = mk_req(1'b1, 32'h10, 32'h11111111, 4'h1);
        a1 = mk_req(1'b1, 32'h20, 32'h22222222, 4'h3);
        rst = 1'b1;
        m_req2 = {a1, a0};
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            e = (t % 2 == 1);
            tick();
            total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL cont_busy t=%0d got=%0b want=1", t, busy2); end
            total++; if (grant2 !== e) begin bad++; $display("FAIL cont_grant t=%0d got=%0d want=%0d", t, grant2, e); end
            total++; if (s_req2 !== (e ? a1 : a0)) begin bad++; $display("FAIL cont_sreq t=%0d got=%h", t, s_req2); end
            s_resp2 = {32'h0, 1'b1};
            tick();
            s_resp2 = '0;
            #1;
            total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL cont_gap t=%0d got=%0b want=0", t, busy2); end
            total++; if (s_req2[RQ-1] !== 1'b0) begin bad++; $display("FAIL cont_gapv t=%0d got=%0b want=0", t, s_req2[RQ-1]); end
        end
        m_req2 = '0;
        tick();
    endtask

    task automatic test_rdata();
        m_req2 = {{RQ{1'b0}}, mk_req(1'b1, 32'h4, 32'h0, 4'h0)};
        tick();
        total++; if (grant2 !== 1'b0) begin bad++; $display("FAIL rd_grant got=%0d want=0", grant2); end
        s_resp2 = {32'h12345678, 1'b1};
        #1;
        total++; if (m_resp2[0 +: RS] !== {32'h12345678, 1'b1}) begin bad++; $display("FAIL rd_resp0 got=%h want=%h", m_resp2[0 +: RS], {32'h12345678, 1'b1}); end
        total++; if (m_resp2[RS +: RS] !== '0) begin bad++; $display("FAIL rd_resp1 got=%h want=0", m_resp2[RS +: RS]); end
        tick();
        m_req2  = '0;
        s_resp2 = '0;
        #1;
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rd_idle got=%0b want=0", busy2); end
    endtask

    task automatic test_spurious();
        s_resp2 = {32'hAAAA5555, 1'b1};
        #1;
        total++; if (m_resp2 !== '0) begin bad++; $display("FAIL spur_resp got=%h want=0", m_resp2); end
        tick();
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL spur_busy got=%0b want=0", busy2); end
        total++; if (s_req2 !== '0) begin bad++; $display("FAIL spur_sreq got=%h want=0", s_req2); end
        total++; if (m_resp2 !== '0) begin bad++; $display("FAIL spur_resp2 got=%h want=0", m_resp2); end
        s_resp2 = '0;
    endtask

    task automatic test_reset_mid();
        logic [RQ-1:0] b0, b1;
        b0 = mk_req(1'b1, 32'h50, 32'h55555555, 4'h5);
        b1 = mk_req(1'b1, 32'h30, 32'h33333333, 4'h7);
        m_req2 = {b1, {RQ{1'b0}}};
        tick();
        total++; if (grant2 !== 1'b1) begin bad++; $display("FAIL rmid_grant got=%0d want=1", grant2); end
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%0b want=1", busy2); end
        rst = 1'b1;
        tick();
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rmid_rbusy got=%0b want=0", busy2); end
        total++; if (s_req2 !== '0) begin bad++; $display("FAIL rmid_sreq got=%h want=0", s_req2); end
        total++; if (grant2 !== 1'b0) begin bad++; $display("FAIL rmid_rgrant got=%0d want=0", grant2); end
        rst = 1'b0;
        m_req2 = {b1, b0};
        s_resp2 = {32'hCAFEF00D, 1'b1};
        #1;
        total++; if (m_resp2 !== '0) begin bad++; $display("FAIL rmid_ready got=%h want=0", m_resp2); end
        tick();
        s_resp2 = '0;
        #1;
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL rmid_next_busy got=%0b want=1", busy2); end
        total++; if (grant2 !== 1'b0) begin bad++; $display("FAIL rmid_next_grant got=%0d want=0", grant2); end
        s_resp2 = {32'h0, 1'b1};
        tick();
        m_req2  = '0;
        s_resp2 = '0;
        tick();
    endtask

    task automatic test_wrap3();
        logic [RQ-1:0] c0, c2;
        logic [1:0]    e;
        c0 = mk_req(1'b1, 32'h40, 32'h44444444, 4'hF);
        c2 = mk_req(1'b1, 32'h60, 32'h66666666, 4'h8);
        m_req3 = {c2, {RQ{1'b0}}, c0};
        for (int t = 0; t < 4; t++) begin
            e = (t % 2 == 1) ? 2'd2 : 2'd0;
            tick();
            total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL wrap_busy t=%0d got=%0b want=1", t, busy3); end
            total++; if (grant3 !== e) begin bad++; $display("FAIL wrap_grant t=%0d got=%0d want=%0d", t, grant3, e); end
            total++; if (s_req3 !== (e == 2'd2 ? c2 : c0)) begin bad++; $display("FAIL wrap_sreq t=%0d got=%h", t, s_req3); end
            s_resp3 = {32'h0, 1'b1};
            #1;
            total++; if (m_resp3[RS +: RS] !== '0) begin bad++; $display("FAIL wrap_resp1 t=%0d got=%h want=0", t, m_resp3[RS +: RS]); end
            tick();
            s_resp3 = '0;
            #1;
            total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL wrap_gap t=%0d got=%0b want=0", t, busy3); end
        end
        m_req3 = '0;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        m_req2  = '0;
        s_resp2 = '0;
        m_req3  = '0;
        s_resp3 = '0;
        test_reset();
        test_single();
        test_contention();
        test_rdata();
        test_spurious();
        test_reset_mid();
        test_wrap3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
